// File: rtl/screen_sequencer_if.sv
// screen_sequencer_if
//   Groups the per-stage drawing-unit handshake and the merged pixel bus.
//   master: sequencer side (drives stage_go and the registered pixel bus,
//           receives stage completion and the per-stage pixel streams).
//   slave : drawing-unit / screen-mux side (the mirror image).
// Signals:
//   stage_go    [NUM_STAGES]          one-hot start pulse per stage
//   stage_done  [NUM_STAGES]          one-cycle completion pulse per stage
//   stage_x     [NUM_STAGES*X_W]      packed x, stage i at [i*X_W +: X_W]
//   stage_y     [NUM_STAGES*Y_W]      packed y
//   stage_color [NUM_STAGES*COLOR_W]  packed colour
//   stage_plot  [NUM_STAGES]          per-stage plot strobes
//   x, y, color, plot                 merged registered pixel output
interface screen_sequencer_if #(
  parameter int NUM_STAGES = 2,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int COLOR_W    = 3
);
  logic [NUM_STAGES-1:0]         stage_go;
  logic [NUM_STAGES-1:0]         stage_done;
  logic [NUM_STAGES*X_W-1:0]     stage_x;
  logic [NUM_STAGES*Y_W-1:0]     stage_y;
  logic [NUM_STAGES*COLOR_W-1:0] stage_color;
  logic [NUM_STAGES-1:0]         stage_plot;
  logic [X_W-1:0]                x;
  logic [Y_W-1:0]                y;
  logic [COLOR_W-1:0]            color;
  logic                          plot;

  modport master (
    output stage_go, x, y, color, plot,
    input  stage_done, stage_x, stage_y, stage_color, stage_plot
  );

  modport slave (
    input  stage_go, x, y, color, plot,
    output stage_done, stage_x, stage_y, stage_color, stage_plot
  );
endinterface

// File: rtl/screen_sequencer.sv
// screen_sequencer
//   Full-screen sequencer: on go, starts NUM_STAGES drawing units one after
//   another, muxes the active unit's pixel stream onto a registered plot bus,
//   then holds for HOLD_TICKS pulses of the 60 Hz tick before raising done.
//   done stays high until go drops, so a held go never re-triggers.
// Optional feature (macro SCREEN_SEQ_SKIP_EN): when defined, skip=1 in HOLD
//   ends the hold on the next edge (priority over tick). When undefined,
//   skip is ignored.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   go     level start request, sampled in IDLE
//   tick   one-cycle 60 Hz pulse
//   skip   early hold termination (SCREEN_SEQ_SKIP_EN only)
//   busy   high in RUN or HOLD
//   done   high in DONE
//   bus    screen_sequencer_if.master: stage handshakes and pixel bus
module screen_sequencer #(
  parameter int NUM_STAGES = 2,
  parameter int HOLD_TICKS = 30,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int COLOR_W    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic tick,
  input  logic skip,
  output logic busy,
  output logic done,
  screen_sequencer_if.master bus
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  // Slot arrays are padded to a power of two so idx can never select
  // outside the array, whatever NUM_STAGES is.
  localparam int SLOTS = 1 << IDX_W;
  localparam int CNT_W = $clog2(HOLD_TICKS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [NUM_STAGES-1:0] stage_go_reg, stage_go_next;
  logic [X_W-1:0]        x_reg;
  logic [Y_W-1:0]        y_reg;
  logic [COLOR_W-1:0]    color_reg;
  logic                  plot_reg;
  logic                  skip_hold;

  // Unpacked per-stage views of the packed input buses.
  logic [X_W-1:0]     x_arr     [SLOTS];
  logic [Y_W-1:0]     y_arr     [SLOTS];
  logic [COLOR_W-1:0] color_arr [SLOTS];
  logic               plot_arr  [SLOTS];
  logic               done_arr  [SLOTS];

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < NUM_STAGES) begin : g_used
        assign x_arr[gi]     = bus.stage_x[gi*X_W +: X_W];
        assign y_arr[gi]     = bus.stage_y[gi*Y_W +: Y_W];
        assign color_arr[gi] = bus.stage_color[gi*COLOR_W +: COLOR_W];
        assign plot_arr[gi]  = bus.stage_plot[gi];
        assign done_arr[gi]  = bus.stage_done[gi];
      end else begin : g_pad
        assign x_arr[gi]     = '0;
        assign y_arr[gi]     = '0;
        assign color_arr[gi] = '0;
        assign plot_arr[gi]  = 1'b0;
        assign done_arr[gi]  = 1'b0;
      end
    end
  endgenerate

`ifdef SCREEN_SEQ_SKIP_EN
  assign skip_hold = skip;
`else
  logic unused_skip;
  assign unused_skip = skip;
  assign skip_hold   = 1'b0;
`endif

  // Next-state logic. Only the active stage's done bit is looked at, so
  // stray completion pulses from other stages fall through.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    cnt_next      = cnt_reg;
    stage_go_next = '0;
    unique case (state_reg)
      S_IDLE: begin
        if (go) begin
          state_next    = S_RUN;
          idx_next      = '0;
          stage_go_next = NUM_STAGES'(1);
        end
      end
      S_RUN: begin
        if (done_arr[idx_reg]) begin
          if (idx_reg == LAST_IDX) begin
            state_next = S_HOLD;
            cnt_next   = '0;
          end else begin
            idx_next      = idx_reg + IDX_W'(1);
            stage_go_next = NUM_STAGES'(1) << (idx_reg + IDX_W'(1));
          end
        end
      end
      S_HOLD: begin
        if (skip_hold) begin
          state_next = S_DONE;
        end else if (tick) begin
          if (cnt_reg == LAST_CNT) begin
            state_next = S_DONE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (!go) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      cnt_reg      <= '0;
      stage_go_reg <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      cnt_reg      <= cnt_next;
      stage_go_reg <= stage_go_next;
    end
  end

  // Pixel mux uses the current idx, so on a hand-off cycle the outgoing
  // stage's last pixel still goes out. Outside RUN coordinates hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg     <= '0;
      y_reg     <= '0;
      color_reg <= '0;
      plot_reg  <= 1'b0;
    end else if (state_reg == S_RUN) begin
      x_reg     <= x_arr[idx_reg];
      y_reg     <= y_arr[idx_reg];
      color_reg <= color_arr[idx_reg];
      plot_reg  <= plot_arr[idx_reg];
    end else begin
      plot_reg  <= 1'b0;
    end
  end

  assign bus.stage_go = stage_go_reg;
  assign bus.x        = x_reg;
  assign bus.y        = y_reg;
  assign bus.color    = color_reg;
  assign bus.plot     = plot_reg;
  assign busy         = (state_reg == S_RUN) || (state_reg == S_HOLD);
  assign done         = (state_reg == S_DONE);

endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer
//   Directed bench for screen_sequencer with NUM_STAGES=2, HOLD_TICKS=3.
//   Stimulus pushes the expected output events (stage_go pulses, done edges,
//   pixel-bus changes) with the cycle they must appear in; an independent
//   monitor samples the DUT on the falling edge and pops/compares.
module tb_screen_sequencer;
  localparam int NS = 2;
  localparam int HT = 3;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;

  localparam int EV_GO   = 0;
  localparam int EV_RISE = 1;
  localparam int EV_FALL = 2;
  localparam int EV_PIX  = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic reset, go, tick, skip;
  logic busy, done;
  logic [NS-1:0] sdone;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   mon_en = 0;
  logic        done_prev;
  logic [31:0] pix_prev;
  ev_t  expq[$];

  screen_sequencer_if #(.NUM_STAGES(NS), .X_W(XW), .Y_W(YW), .COLOR_W(CW)) bus ();

  screen_sequencer #(
    .NUM_STAGES(NS), .HOLD_TICKS(HT), .X_W(XW), .Y_W(YW), .COLOR_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .tick(tick), .skip(skip),
    .busy(busy), .done(done), .bus(bus)
  );

  // Stage 0: (5,7,000,plot); stage 1: (100,100,111,plot).
  assign bus.stage_x     = {9'd100, 9'd5};
  assign bus.stage_y     = {8'd100, 8'd7};
  assign bus.stage_color = {3'b111, 3'b000};
  assign bus.stage_plot  = 2'b11;
  assign bus.stage_done  = sdone;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pixw(logic p, logic [2:0] c, logic [7:0] yy, logic [8:0] xx);
    return {11'd0, p, c, yy, xx};
  endfunction

  task automatic push(int kind, int at, logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.data = data;
    expq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic observe(int kind, logic [31:0] data);
    ev_t e;
    n_vec++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: kind=%0d data=%h at cycle %0d, expected none", kind, data, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.data !== data) begin
        n_bad++;
        $display("FAIL event: got kind=%0d data=%h cycle=%0d, expected kind=%0d data=%h cycle=%0d",
                 kind, data, cyc, e.kind, e.data, e.cyc);
      end else begin
        $display("ok   event kind=%0d data=%h cycle=%0d", kind, data, cyc);
      end
    end
  endtask

  // Monitor: independent of the stimulus process.
  always @(negedge clk) begin
    logic [31:0] pix;
    if (mon_en) begin
      pix = pixw(bus.plot, bus.color, bus.y, bus.x);
      if (bus.stage_go != '0) observe(EV_GO, {30'd0, bus.stage_go});
      if (done && !done_prev) observe(EV_RISE, 32'd0);
      if (!done && done_prev) observe(EV_FALL, 32'd0);
      if (pix !== pix_prev)   observe(EV_PIX, pix);
      done_prev = done;
      pix_prev  = pix;
    end
  end

  task automatic pulse_done(logic [NS-1:0] b);
    sdone = b;
    step();
    sdone = '0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    logic [31:0] p0, p1, p1_off;
    p0     = pixw(1'b1, 3'b000, 8'd7, 9'd5);
    p1     = pixw(1'b1, 3'b111, 8'd100, 9'd100);
    p1_off = pixw(1'b0, 3'b111, 8'd100, 9'd100);

    reset = 1'b1; go = 1'b0; tick = 1'b0; skip = 1'b0; sdone = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    done_prev = 1'b0;
    pix_prev  = 32'd0;
    mon_en    = 1;

    // Reset state.
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_stage_go", {30'd0, bus.stage_go}, 32'd0);
    chk("rst_pixel", pixw(bus.plot, bus.color, bus.y, bus.x), 32'd0);

    // Stray events while idle.
    pulse_done(2'b01);
    pulse_tick();
    repeat (2) step();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // ---- Full sequence ----
    go = 1'b1;
    push(EV_GO, cyc + 1, 32'd1);
    push(EV_PIX, cyc + 2, p0);
    step();
    chk("run_busy", {31'd0, busy}, 32'd1);
    repeat (5) step();
    pulse_done(2'b10);           // non-active stage: ignored
    pulse_tick();                // tick in RUN: ignored
    repeat (12) step();
    push(EV_GO, cyc + 1, 32'd2);
    push(EV_PIX, cyc + 2, p1);
    pulse_done(2'b01);
    repeat (39) step();
    push(EV_PIX, cyc + 2, p1_off);
    pulse_done(2'b10);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    step();
    chk("hold_plot", {31'd0, bus.plot}, 32'd0);
    for (int i = 0; i < HT; i++) begin
      repeat (4) step();
      if (i == HT - 1) push(EV_RISE, cyc + 1, 32'd0);
      pulse_tick();
      if (i == HT - 2) chk("hold_not_done", {31'd0, done}, 32'd0);
    end
    chk("done_busy", {31'd0, busy}, 32'd0);
    repeat (5) step();
    chk("done_held_go", {31'd0, done}, 32'd1);
    go = 1'b0;
    push(EV_FALL, cyc + 1, 32'd0);
    step();
    repeat (3) step();

    // ---- Reset mid-HOLD after 2 ticks ----
    go = 1'b1;
    push(EV_GO, cyc + 1, 32'd1);
    push(EV_PIX, cyc + 2, p0);
    step();
    repeat (3) step();
    push(EV_GO, cyc + 1, 32'd2);
    push(EV_PIX, cyc + 2, p1);
    pulse_done(2'b01);
    repeat (3) step();
    push(EV_PIX, cyc + 2, p1_off);
    pulse_done(2'b10);
    step();
    pulse_tick();
    step();
    pulse_tick();
    reset = 1'b1;
    go    = 1'b0;
    push(EV_PIX, cyc + 1, 32'd0);
    step();
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_pixel", pixw(bus.plot, bus.color, bus.y, bus.x), 32'd0);
    repeat (2) step();

    // ---- Restart; go drops in RUN; done+tick coincide; skip in HOLD ----
    go = 1'b1;
    push(EV_GO, cyc + 1, 32'd1);
    push(EV_PIX, cyc + 2, p0);
    step();
    go = 1'b0;
    repeat (3) step();
    push(EV_GO, cyc + 1, 32'd2);
    push(EV_PIX, cyc + 2, p1);
    pulse_done(2'b01);
    repeat (3) step();
    push(EV_PIX, cyc + 2, p1_off);
    tick = 1'b1;                 // coincides with RUN->HOLD: not counted
    pulse_done(2'b10);
    tick = 1'b0;
    step();
    pulse_tick();                // first counted tick
    step();
`ifdef SCREEN_SEQ_SKIP_EN
    push(EV_RISE, cyc + 1, 32'd0);
    push(EV_FALL, cyc + 2, 32'd0);
    skip = 1'b1;
    step();
    skip = 1'b0;
`else
    skip = 1'b1;
    step();
    skip = 1'b0;
    chk("skip_ignored", {31'd0, done}, 32'd0);
    step();
    pulse_tick();
    step();
    push(EV_RISE, cyc + 1, 32'd0);
    push(EV_FALL, cyc + 2, 32'd0);
    pulse_tick();
`endif
    repeat (5) step();

    chk("pending_events", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Parametrised full-screen sequencer for the VGA game display path. On `go` it fires up to NUM_STAGES drawing units one after another: stage 0 is typically the black-screen clear, later stages draw sprites or squares. It muxes the active stage's pixel stream onto a single registered plot bus, then holds for HOLD_TICKS pulses of the 60 Hz tick before asserting `done`. It is the common engine for the win, game-over and title screens, and feeds the top-level screen mux.

## Interface
- NUM_STAGES, 2, number of chained drawing stages (1..4)
- HOLD_TICKS, 30, tick pulses to hold after the last stage finishes (>=1)
- X_W, 9, x coordinate width
- Y_W, 8, y coordinate width
- COLOR_W, 3, colour width

- clk  in  1  system clock (50 MHz); the only clock
- reset  in  1  synchronous, active-high reset
- go  in  1  level; start request, sampled in IDLE
- tick  in  1  one-cycle 60 Hz pulse, synchronous to clk
- skip  in  1  early hold termination; only used with SCREEN_SEQ_SKIP_EN
- stage_go  out  NUM_STAGES  one-hot one-cycle start pulse to each stage
- stage_done  in  NUM_STAGES  one-cycle completion pulse from each stage
- stage_x  in  NUM_STAGES*X_W  packed x buses; stage i at [i*X_W +: X_W]
- stage_y  in  NUM_STAGES*Y_W  packed y buses
- stage_color  in  NUM_STAGES*COLOR_W  packed colour buses
- stage_plot  in  NUM_STAGES  per-stage plot strobes
- x  out  X_W  registered pixel x
- y  out  Y_W  registered pixel y
- color  out  COLOR_W  registered pixel colour
- plot  out  1  registered plot strobe
- busy  out  1  high in RUN or HOLD
- done  out  1  high in DONE

## Operation
- States: IDLE, RUN, HOLD, DONE. A stage index `idx` (width clog2(NUM_STAGES), minimum 1) selects the active stage in RUN.
- IDLE: if go=1, go to RUN with idx=0 and pulse stage_go[0] in the same transition cycle. The pulse is registered, so it appears the cycle after go is sampled.
- RUN: stage_done[idx]=1 with idx<NUM_STAGES-1 → idx+1 and pulse stage_go[idx+1]. stage_done[idx]=1 with idx=NUM_STAGES-1 → HOLD, with the hold counter cleared.
- stage_done bits for non-active stages are ignored.
- tick is ignored in RUN.
- go falling during RUN or HOLD is ignored; the sequence always completes.
- HOLD: each tick increments the counter. tick with counter=HOLD_TICKS-1 → DONE.
- Counter width is clog2(HOLD_TICKS+1). The counter never wraps.
- DONE: done=1. go=0 → IDLE on the next edge. If go is still 1, the block stays in DONE; it never re-triggers without go first dropping.
- Pixel mux: in RUN, x/y/color/plot register the stage[idx] slice every cycle. Outside RUN, plot is registered 0 and x/y/color hold their last values.
- On a stage hand-off cycle, the outgoing stage's pixel from that cycle is still forwarded.

## Timing
- Reset (synchronous, highest priority): state=IDLE, idx=0, counter=0, stage_go=0, x=0, y=0, color=0, plot=0, busy=0, done=0.
- Reset mid-operation aborts immediately. Any stage already started is not stopped by this block.
- Latencies:
  - go → stage_go[0]: 1 cycle.
  - stage_done[i] → stage_go[i+1]: 1 cycle.
  - Pixel input → output: 1 cycle.
- Last stage_done → busy stays 1 (HOLD). HOLD → done: on the edge after the HOLD_TICKS-th tick.
- If go is already 0 when DONE is entered, done is high for exactly 1 cycle.
- tick and stage_done arriving in the same cycle as the RUN→HOLD transition: that tick is not counted.

## Configuration
- SCREEN_SEQ_SKIP_EN defined: skip=1 in HOLD → DONE on the next edge, regardless of the counter. skip has priority over tick. skip in IDLE, RUN or DONE has no effect.
- SCREEN_SEQ_SKIP_EN undefined: skip is ignored entirely; HOLD always lasts exactly HOLD_TICKS ticks.

## Test plan
- Reset then idle (NUM_STAGES=2, HOLD_TICKS=3): all outputs 0. Pulsing stage_done[0] and tick gives no stage_go and no state change.
- Full sequence:
  - Stimulus: go=1, stage_done[0] 20 cycles after stage_go[0], stage_done[1] 40 cycles later, then 3 ticks, then go=0.
  - Required: stage_go[0] at cycle 1; stage_go[1] 1 cycle after stage_done[0]; done 1 cycle after the 3rd tick; done falls 1 cycle after go=0.
- Pixel mux: stage 0 drives (5,7,3'b000,plot=1) and stage 1 drives (100,100,3'b111,plot=1). Output shows stage 0's values during RUN idx 0, then stage 1's values, each delayed 1 cycle. plot=0 throughout HOLD.
- Stray events: stage_done[1] during idx 0 is ignored. tick during RUN does not shorten HOLD; exactly 3 ticks are still required.
- Reset mid-HOLD after 2 ticks: next cycle is IDLE with all outputs 0. A new go restarts from stage 0.
- With SCREEN_SEQ_SKIP_EN: skip=1 one tick into HOLD → done on the next edge. Without the macro, the same stimulus still needs 3 ticks.
